// File: rtl/ysyx_23060332_mem_slave_pkg.sv
// Shared definitions for the handshaked data-memory slave.
//   mem_state_e : slave FSM encoding (idle / waiting for access edge / holding response)
//   MemBase/Size: default legal address window (byte addresses, BASE..BASE+SIZE-1)
//   cnt_width() : width of the latency down-counter for a given pair of latencies
package ysyx_23060332_mem_slave_pkg;

  typedef enum logic [1:0] {
    MemIdle = 2'd0,
    MemWait = 2'd1,
    MemResp = 2'd2
  } mem_state_e;

  localparam logic [31:0] MemBase = 32'h8000_0000;
  localparam logic [31:0] MemSize = 32'h0800_0000;

  // The counter only ever holds LAT-1, so clog2 of the larger latency suffices (min 1 bit).
  function automatic int unsigned cnt_width(input int unsigned rd_lat, input int unsigned wr_lat);
    int unsigned m;
    m = (rd_lat > wr_lat) ? rd_lat : wr_lat;
    return (m <= 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/ysyx_23060332_mem_slave_if.sv
// Request/response bus between a memory master (LSU/IFU) and ysyx_23060332_mem_slave.
//   req_valid/req_ready : request handshake, fields req_wen/req_addr/req_wdata/req_wmask
//   resp_valid/resp_ready : response handshake, fields resp_rdata/resp_err
//   busy : slave has a transaction in flight
// modport master drives requests and accepts responses; modport slave is the mirror image.
interface ysyx_23060332_mem_slave_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned MASK_W = DATA_W / 8;

  logic              req_valid;
  logic              req_ready;
  logic              req_wen;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [MASK_W-1:0] req_wmask;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;
  logic              busy;

  modport master (
    output req_valid, req_wen, req_addr, req_wdata, req_wmask, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err, busy
  );

  modport slave (
    input  req_valid, req_wen, req_addr, req_wdata, req_wmask, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err, busy
  );

endinterface

// File: rtl/ysyx_23060332_lat_cnt.sv
// Loadable down-counter with a zero flag.
//   clk, rst  : clock, asynchronous active-high reset (count cleared)
//   load      : load load_val this edge (has priority over dec)
//   load_val  : value to load
//   dec       : decrement this edge; saturates at zero
//   zero      : count is zero
module ysyx_23060332_lat_cnt #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [WIDTH-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/ysyx_23060332_mem_slave.sv
// Handshaked data-memory slave with programmable read/write latency and an address window.
//   clk, rst   : clock, asynchronous active-high reset
//   bus        : slave side of ysyx_23060332_mem_slave_if (request/response handshakes, busy)
//   pmem_*     : physical memory port. pmem_en is high for exactly one cycle per legal
//                transaction; the memory must act on the rising edge that ends that cycle
//                (write when pmem_wen, otherwise present the word at pmem_addr on pmem_rdata,
//                combinationally, so it is captured on that same edge).
// One transaction in flight at a time: fire in IDLE, wait LAT edges, then hold the response
// until the master takes it.
module ysyx_23060332_mem_slave
  import ysyx_23060332_mem_slave_pkg::*;
#(
  parameter int unsigned       ADDR_W = 32,
  parameter int unsigned       DATA_W = 32,
  parameter logic [ADDR_W-1:0] BASE   = MemBase,
  parameter logic [ADDR_W-1:0] SIZE   = MemSize,
  parameter int unsigned       RD_LAT = 1,
  parameter int unsigned       WR_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  ysyx_23060332_mem_slave_if.slave bus,
  output logic                  pmem_en,
  output logic                  pmem_wen,
  output logic [ADDR_W-1:0]     pmem_addr,
  output logic [DATA_W-1:0]     pmem_wdata,
  output logic [DATA_W/8-1:0]   pmem_wmask,
  input  logic [DATA_W-1:0]     pmem_rdata
);

  localparam int unsigned MASK_W = DATA_W / 8;
  localparam int unsigned CntW   = cnt_width(RD_LAT, WR_LAT);

  localparam logic [CntW-1:0] RdLoad = CntW'(RD_LAT - 1);
  localparam logic [CntW-1:0] WrLoad = CntW'(WR_LAT - 1);

  // One extra bit so BASE+SIZE cannot wrap; upper bound is exclusive.
  localparam logic [ADDR_W:0] WinLo = {1'b0, BASE};
  localparam logic [ADDR_W:0] WinHi = {1'b0, BASE} + {1'b0, SIZE};

  mem_state_e        state_q;
  logic              wen_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [MASK_W-1:0] wmask_q;
  logic              legal_q;
  logic              req_ready_q;
  logic              resp_valid_q;
  logic [DATA_W-1:0] resp_rdata_q;
  logic              resp_err_q;
  logic              busy_q;

  logic              fire;
  logic              in_window;
  logic              cnt_zero;
  logic              access;
  logic [ADDR_W:0]   req_addr_ext;

  assign fire         = bus.req_valid && req_ready_q;
  assign req_addr_ext = {1'b0, bus.req_addr};
  assign in_window    = (req_addr_ext >= WinLo) && (req_addr_ext < WinHi);

  // Access happens on the edge that ends the last WAIT cycle.
  assign access = (state_q == MemWait) && cnt_zero;

  ysyx_23060332_lat_cnt #(
    .WIDTH (CntW)
  ) u_lat_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (fire),
    .load_val (bus.req_wen ? WrLoad : RdLoad),
    .dec      (state_q == MemWait),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= MemIdle;
      wen_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wmask_q      <= '0;
      legal_q      <= 1'b0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      unique case (state_q)
        MemIdle: begin
          if (fire) begin
            state_q     <= MemWait;
            wen_q       <= bus.req_wen;
            addr_q      <= bus.req_addr;
            wdata_q     <= bus.req_wdata;
            wmask_q     <= bus.req_wmask;
            legal_q     <= in_window;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
          end
        end
        MemWait: begin
          if (cnt_zero) begin
            state_q      <= MemResp;
            resp_valid_q <= 1'b1;
            resp_err_q   <= !legal_q;
            // Writes and rejected accesses return zero data.
            resp_rdata_q <= (legal_q && !wen_q) ? pmem_rdata : '0;
          end
        end
        MemResp: begin
          if (bus.resp_ready) begin
            state_q      <= MemIdle;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            req_ready_q  <= 1'b1;
            busy_q       <= 1'b0;
          end
        end
        default: begin
          state_q <= MemIdle;
        end
      endcase
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.busy       = busy_q;

  // Out-of-window requests never reach memory.
  assign pmem_en    = access && legal_q;
  assign pmem_wen   = wen_q;
  assign pmem_addr  = addr_q;
  assign pmem_wdata = wdata_q;
  assign pmem_wmask = wmask_q;

endmodule
